// File: rtl/mips_mmio_pkg.sv
// ----------------------------------------------------------------------------
// mips_mmio_pkg : register map, CTRL layout and FSM encoding for the MMIO timer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_mmio_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Packed so that the struct maps directly onto CTRL[3:0].
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

  function automatic logic is_auto(input logic [1:0] mode);
    return mode == MODE_AUTO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_timer_responder_if.sv
// ----------------------------------------------------------------------------
// mips_timer_responder_if : req/ready register bus between CPU bridge and timer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mips_timer_responder_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ready;
  logic             irq;

  modport master (output req, we, addr, wdata, input rdata, ready, irq);
  modport slave  (input req, we, addr, wdata, output rdata, ready, irq);
endinterface

`default_nettype wire

// File: rtl/mips_timer_core.sv
// ----------------------------------------------------------------------------
// mips_timer_core : countdown FSM, COUNT register and interrupt request
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_timer_core
  import mips_mmio_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_im,
  input  logic [WIDTH-1:0] i_preset,
  input  logic             i_ctrl_wr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_irq,
  output logic             o_en_clr
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_irq;
  logic             w_irq_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    o_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: if (i_en) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_count_nxt = i_preset;
        if (!i_en)                 w_state_nxt = ST_IDLE;
        else if (i_preset == '0)   w_state_nxt = ST_INT;
        else                       w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        // INT is taken as COUNT reaches zero, so the decrement never wraps.
        if (i_en) begin
          w_count_nxt = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
          if (r_count == {{(WIDTH-1){1'b0}}, 1'b1}) w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (is_auto(i_mode) && i_en) begin
          w_state_nxt = ST_LOAD;
        end else begin
          o_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // One-shot irq latches until a CTRL write; auto-reload irq is a single-cycle pulse.
  always_comb begin
    if (!i_im)                              w_irq_nxt = 1'b0;
    else if (w_state_nxt == ST_INT)         w_irq_nxt = 1'b1;
    else if (is_auto(i_mode) || i_ctrl_wr)  w_irq_nxt = 1'b0;
    else                                    w_irq_nxt = r_irq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign o_count = r_count;
  assign o_irq   = r_irq;

endmodule

`default_nettype wire

// File: rtl/mips_timer_responder.sv
// ----------------------------------------------------------------------------
// mips_timer_responder : MMIO timer register file and req/ready bus responder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_timer_responder
  import mips_mmio_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_timer_responder_if.slave  bus
);

  tmr_ctrl_t        r_ctrl;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_rdata;
  logic             r_ready;
  logic             r_pend;
  logic [1:0]       r_addr;

  logic             w_accept;
  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_en_clr;
  logic             w_irq;
  logic [WIDTH-1:0] w_count;
  logic [1:0]       w_rsel;
  logic [WIDTH-1:0] w_rword;

  assign w_accept  = bus.req && !r_ready && !r_pend;
  assign w_wr      = w_accept && bus.we;
  assign w_ctrl_wr = w_wr && (bus.addr == TMR_CTRL);

  // A two-cycle read samples the register selected at accept, one cycle later.
  assign w_rsel = r_pend ? r_addr : bus.addr;

  always_comb begin
    case (w_rsel)
      TMR_CTRL:   w_rword = {{(WIDTH-4){1'b0}}, r_ctrl};
      TMR_PRESET: w_rword = r_preset;
      TMR_COUNT:  w_rword = w_count;
      default:    w_rword = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl   <= '{im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};
      r_preset <= '0;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_pend   <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_ready <= 1'b0;
      // A CPU CTRL write overrides the FSM's EN clear on the same edge.
      if (w_ctrl_wr) begin
        r_ctrl <= '{im:   bus.wdata[CTRL_IM],
                    mode: bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO],
                    en:   bus.wdata[CTRL_EN]};
      end else if (w_en_clr) begin
        r_ctrl.en <= 1'b0;
      end
      if (w_wr && (bus.addr == TMR_PRESET)) r_preset <= bus.wdata;

      if (r_pend) begin
        r_rdata <= w_rword;
        r_ready <= 1'b1;
        r_pend  <= 1'b0;
      end else if (w_accept) begin
        if (bus.we) begin
          r_ready <= 1'b1;
        end else if (RD_LAT == 1) begin
          r_rdata <= w_rword;
          r_ready <= 1'b1;
        end else begin
          r_pend <= 1'b1;
          r_addr <= bus.addr;
        end
      end
    end
  end

  mips_timer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_ctrl.en),
    .i_mode    (r_ctrl.mode),
    .i_im      (r_ctrl.im),
    .i_preset  (r_preset),
    .i_ctrl_wr (w_ctrl_wr),
    .o_count   (w_count),
    .o_irq     (w_irq),
    .o_en_clr  (w_en_clr)
  );

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.irq   = w_irq;

endmodule

`default_nettype wire

// File: tb/tb_mips_timer_responder.sv
// ----------------------------------------------------------------------------
// tb_mips_timer_responder : directed stimulus with a ready-driven scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mips_timer_responder;
  import mips_mmio_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_timer_responder_if #(.WIDTH(32)) b1 ();
  mips_timer_responder_if #(.WIDTH(32)) b2 ();

  mips_timer_responder #(.WIDTH(32), .RD_LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  mips_timer_responder #(.WIDTH(32), .RD_LAT(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] ex);
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, ex, cyc);
    end
  endtask

  task automatic sb_check(input string nm, input bit empty, input exp_t e, input logic [31:0] rdata);
    checks++;
    if (empty) begin
      failures++;
      $display("FAIL %s: ready with no outstanding request (cycle %0d)", nm, cyc);
    end else begin
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s_latency: ready at cycle %0d expected cycle %0d", nm, cyc, e.cyc);
      end
      if (e.rd) begin
        checks++;
        if (rdata !== e.data) begin
          failures++;
          $display("FAIL %s_rdata: got 0x%0h expected 0x%0h", nm, rdata, e.data);
        end
      end
    end
  endtask

  exp_t none_e;
  initial begin
    none_e.cyc  = 0;
    none_e.rd   = 1'b0;
    none_e.data = '0;
  end

  always @(negedge clk) begin
    if (b1.ready) begin
      if (q1.size() == 0) sb_check("sb1", 1'b1, none_e, b1.rdata);
      else                sb_check("sb1", 1'b0, q1.pop_front(), b1.rdata);
    end
    if (b2.ready) begin
      if (q2.size() == 0) sb_check("sb2", 1'b1, none_e, b2.rdata);
      else                sb_check("sb2", 1'b0, q2.pop_front(), b2.rdata);
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 1) ? b1.ready : b2.ready;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge ending the ready cycle.
  task automatic bus_op(input int sel, input bit w, input logic [1:0] a,
                        input logic [31:0] wd, input logic [31:0] ex);
    exp_t e;
    int   n;
    e.cyc  = cyc + ((sel == 2 && !w) ? 2 : 1);
    e.rd   = !w;
    e.data = ex;
    if (sel == 1) begin
      q1.push_back(e);
      b1.req = 1'b1; b1.we = w; b1.addr = a; b1.wdata = wd;
    end else begin
      q2.push_back(e);
      b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = wd;
    end
    tick(1);
    n = 0;
    while (!rdy(sel) && n < 8) begin
      tick(1);
      n++;
    end
    if (!rdy(sel)) begin
      checks++;
      failures++;
      $display("FAIL timeout: no ready on bus %0d addr %0d", sel, a);
    end
    if (sel == 1) b1.req = 1'b0;
    else          b2.req = 1'b0;
    tick(1);
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
    bus_op(sel, 1'b1, a, d, 32'h0);
  endtask

  task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] ex);
    bus_op(sel, 1'b0, a, 32'h0, ex);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = '0; b2.wdata = '0;
    do_reset();

    // Reset asserted mid-count with COUNT=5 and stale rdata on the bus.
    wr(1, TMR_PRESET, 32'd10);
    wr(1, TMR_CTRL, 32'h1);
    tick(4);
    rd(1, TMR_COUNT, 32'd7);
    reset = 1'b0;
    #1;
    chk("rst_ready", b1.ready, 0);
    chk("rst_irq",   b1.irq,   0);
    chk("rst_rdata", b1.rdata, 0);
    @(negedge clk) reset = 1'b1;
    tick(1);
    rd(1, TMR_COUNT,  32'd0);
    rd(1, TMR_CTRL,   32'd0);
    rd(1, TMR_PRESET, 32'd0);

    // One-shot countdown with latched irq.
    do_reset();
    wr(1, TMR_PRESET, 32'd3);
    wr(1, TMR_CTRL, 32'h9);
    tick(1);
    rd(1, TMR_COUNT, 32'd3);
    chk("os_irq_before", b1.irq, 0);
    rd(1, TMR_COUNT, 32'd1);
    chk("os_irq_set", b1.irq, 1);
    rd(1, TMR_COUNT, 32'd0);
    rd(1, TMR_CTRL, 32'h8);
    chk("os_irq_held", b1.irq, 1);
    wr(1, TMR_CTRL, 32'h0);
    chk("os_irq_clr", b1.irq, 0);

    // Auto-reload: one-cycle irq pulse every four cycles.
    do_reset();
    wr(1, TMR_PRESET, 32'd2);
    wr(1, TMR_CTRL, 32'hB);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("auto_irq_%0d", i), b1.irq, (i % 4 == 3) ? 1 : 0);
      tick(1);
    end
    rd(1, TMR_CTRL, 32'hB);

    // Handshake latency on both read latencies; COUNT is read-only.
    do_reset();
    wr(1, TMR_PRESET, 32'd100);
    wr(1, TMR_CTRL, 32'h1);
    tick(2);
    rd(1, TMR_COUNT, 32'd99);
    wr(1, TMR_COUNT, 32'h55);
    rd(1, TMR_COUNT, 32'd95);
    rd(1, 2'd3, 32'd0);
    wr(2, TMR_PRESET, 32'd100);
    wr(2, TMR_CTRL, 32'h1);
    tick(2);
    rd(2, TMR_COUNT, 32'd98);
    wr(2, TMR_COUNT, 32'h55);
    rd(2, TMR_COUNT, 32'd93);
    rd(2, TMR_PRESET, 32'd100);

    // Pause at COUNT=4, resume without restart, then PRESET=0.
    do_reset();
    wr(1, TMR_PRESET, 32'd10);
    wr(1, TMR_CTRL, 32'h1);
    tick(6);
    wr(1, TMR_CTRL, 32'h0);
    tick(3);
    rd(1, TMR_COUNT, 32'd4);
    rd(1, TMR_CTRL, 32'h0);
    wr(1, TMR_CTRL, 32'h1);
    rd(1, TMR_COUNT, 32'd3);
    do_reset();
    wr(1, TMR_PRESET, 32'd0);
    wr(1, TMR_CTRL, 32'h9);
    chk("p0_irq_load", b1.irq, 0);
    tick(1);
    chk("p0_irq_int", b1.irq, 1);
    rd(1, TMR_COUNT, 32'd0);

    // Masked interrupt never rises.
    do_reset();
    wr(1, TMR_PRESET, 32'd1);
    wr(1, TMR_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mask_irq_%0d", i), b1.irq, 0);
      tick(1);
    end
    rd(1, TMR_CTRL, 32'h0);

    // CPU CTRL write collides with the FSM clearing EN in INT.
    do_reset();
    wr(1, TMR_PRESET, 32'd1);
    wr(1, TMR_CTRL, 32'h9);
    tick(2);
    chk("col_irq_int", b1.irq, 1);
    wr(1, TMR_CTRL, 32'h9);
    chk("col_irq_clr", b1.irq, 0);
    rd(1, TMR_CTRL, 32'h9);
    chk("col_irq_again", b1.irq, 1);

    tick(2);
    chk("sb1_drain", q1.size(), 0);
    chk("sb2_drain", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
